// File: rtl/dtw_frame_streamer.sv
// Transmit side of the DTW sample interface: holds one test utterance, streams it with each stored
// template into the DTW core, and keeps the template index that produced the smallest distance.
module dtw_frame_streamer #(
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 11,
    parameter int NUM_TMPL     = 4,
    parameter int WAIT_TIMEOUT = 65535,
    localparam int TI_W        = (NUM_TMPL > 1) ? $clog2(NUM_TMPL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_wr_en,
    input  logic [DATA_W-1:0] test_wr_data,
    input  logic              test_clear,
    output logic [ADDR_W-1:0] test_len,
    output logic              test_full,
    input  logic              go,
    output logic [TI_W-1:0]   tmpl_idx,
    output logic [ADDR_W-1:0] tmpl_addr,
    input  logic [DATA_W-1:0] tmpl_data,
    input  logic [ADDR_W-1:0] tmpl_len,
    output logic [DATA_W-1:0] InSample,
    output logic [DATA_W-1:0] InTest,
    output logic              StartReceiveSample,
    output logic              StartReceiveTest,
    output logic              Start,
    output logic              dtw_rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] Out_Euclidean_Distatnce,
    output logic              busy,
    output logic              done,
    output logic [TI_W-1:0]   best_idx,
    output logic [DATA_W-1:0] best_dist,
    output logic              timeout
);

    typedef enum logic [2:0] {
        IDLE, CLR, SEND, GAP, KICK, WAIT, NEXT, DONE
    } state_t;

    state_t            state_q;
    logic [TI_W-1:0]   tmpl_idx_q;
    logic [ADDR_W-1:0] k_q;
    logic              gap_q;
    logic [31:0]       wait_q;
    logic [DATA_W-1:0] dist_q;
    logic [DATA_W-1:0] best_dist_q;
    logic [TI_W-1:0]   best_idx_q;
    logic              timeout_q;
    logic              busy_q;
    logic              done_q;
    logic              start_q;
    logic              dtw_rst_q;
    logic              samp_stb_q;
    logic              test_stb_q;
    logic [DATA_W-1:0] sample_hold_q;
    logic [DATA_W-1:0] test_rd_q;
    logic [ADDR_W-1:0] test_len_q;

    logic [DATA_W-1:0] test_mem [0:(1<<ADDR_W)-1];

    logic              test_full_d;
    logic              test_we_d;
    logic [ADDR_W-1:0] send_max_d;

    assign test_full_d = (test_len_q == {ADDR_W{1'b1}});
    assign test_we_d   = (state_q == IDLE) && !test_clear && test_wr_en && !test_full_d;
    assign send_max_d  = (tmpl_len > test_len_q) ? tmpl_len : test_len_q;

    always_ff @(posedge clk) begin
        if (test_we_d) begin
            test_mem[test_len_q] <= test_wr_data;
        end
    end

    // Test samples come out of the RAM read register, which only moves while the test stream is live.
    always_ff @(posedge clk) begin
        if (rst) begin
            test_rd_q <= '0;
        end else if (state_q == SEND && k_q < test_len_q) begin
            test_rd_q <= test_mem[k_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tmpl_idx_q    <= '0;
            k_q           <= '0;
            gap_q         <= 1'b0;
            wait_q        <= '0;
            dist_q        <= '0;
            best_dist_q   <= '1;
            best_idx_q    <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            dtw_rst_q     <= 1'b0;
            samp_stb_q    <= 1'b0;
            test_stb_q    <= 1'b0;
            sample_hold_q <= '0;
            test_len_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            dtw_rst_q  <= 1'b0;
            samp_stb_q <= 1'b0;
            test_stb_q <= 1'b0;
            if (samp_stb_q) begin
                sample_hold_q <= tmpl_data;
            end

            case (state_q)
                IDLE: begin
                    if (test_clear) begin
                        test_len_q <= '0;
                    end else if (test_we_d) begin
                        test_len_q <= test_len_q + ADDR_W'(1);
                    end
                    if (go && test_len_q != '0) begin
                        tmpl_idx_q  <= '0;
                        best_dist_q <= '1;
                        best_idx_q  <= '0;
                        timeout_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        dtw_rst_q   <= 1'b1;
                        state_q     <= CLR;
                    end
                end
                CLR: begin
                    k_q <= '0;
                    if (tmpl_len == '0) begin
                        dist_q  <= '1;
                        state_q <= NEXT;
                    end else begin
                        state_q <= SEND;
                    end
                end
                // Address k goes out this cycle; its data and strobe are presented next cycle.
                SEND: begin
                    samp_stb_q <= (k_q < tmpl_len);
                    test_stb_q <= (k_q < test_len_q);
                    if (k_q == send_max_d) begin
                        gap_q   <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        k_q <= k_q + ADDR_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q) begin
                        start_q <= 1'b1;
                        state_q <= KICK;
                    end else begin
                        gap_q <= 1'b1;
                    end
                end
                KICK: begin
                    wait_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (valid) begin
                        dist_q  <= Out_Euclidean_Distatnce;
                        state_q <= NEXT;
                    end else if (wait_q == 32'(WAIT_TIMEOUT - 1)) begin
                        dist_q    <= '1;
                        timeout_q <= 1'b1;
                        state_q   <= NEXT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                NEXT: begin
                    if (dist_q < best_dist_q) begin
                        best_dist_q <= dist_q;
                        best_idx_q  <= tmpl_idx_q;
                    end
                    if (tmpl_idx_q == TI_W'(NUM_TMPL - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        tmpl_idx_q <= tmpl_idx_q + TI_W'(1);
                        dtw_rst_q  <= 1'b1;
                        state_q    <= CLR;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Template memory data is forwarded straight through while its strobe is high, then held.
    assign InSample           = samp_stb_q ? tmpl_data : sample_hold_q;
    assign InTest             = test_rd_q;
    assign StartReceiveSample = samp_stb_q;
    assign StartReceiveTest   = test_stb_q;
    assign Start              = start_q;
    assign dtw_rst            = dtw_rst_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign best_idx           = best_idx_q;
    assign best_dist          = best_dist_q;
    assign timeout            = timeout_q;
    assign tmpl_idx           = tmpl_idx_q;
    assign tmpl_addr          = k_q;
    assign test_len           = test_len_q;
    assign test_full          = test_full_d;

endmodule

// File: tb/tb_dtw_frame_streamer.sv
// Bench for dtw_frame_streamer: vector table of scans with a stream scoreboard, plus buffer-fill and reset corner cases.
module tb_dtw_frame_streamer;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 11;
    localparam int TI_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              test_wr_en;
    logic [DATA_W-1:0] test_wr_data;
    logic              test_clear;
    logic [ADDR_W-1:0] test_len;
    logic              test_full;
    logic              go;
    logic [TI_W-1:0]   tmpl_idx;
    logic [ADDR_W-1:0] tmpl_addr;
    logic [DATA_W-1:0] tmpl_data;
    logic [ADDR_W-1:0] tmpl_len;
    logic [DATA_W-1:0] InSample;
    logic [DATA_W-1:0] InTest;
    logic              StartReceiveSample;
    logic              StartReceiveTest;
    logic              Start;
    logic              dtw_rst;
    logic              valid;
    logic [DATA_W-1:0] Out_Euclidean_Distatnce;
    logic              busy;
    logic              done;
    logic [TI_W-1:0]   best_idx;
    logic [DATA_W-1:0] best_dist;
    logic              timeout;

    dtw_frame_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TMPL(4), .WAIT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .test_wr_en(test_wr_en), .test_wr_data(test_wr_data), .test_clear(test_clear),
        .test_len(test_len), .test_full(test_full), .go(go),
        .tmpl_idx(tmpl_idx), .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .tmpl_len(tmpl_len),
        .InSample(InSample), .InTest(InTest),
        .StartReceiveSample(StartReceiveSample), .StartReceiveTest(StartReceiveTest),
        .Start(Start), .dtw_rst(dtw_rst), .valid(valid),
        .Out_Euclidean_Distatnce(Out_Euclidean_Distatnce),
        .busy(busy), .done(done), .best_idx(best_idx), .best_dist(best_dist), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0]      testLen;
        logic [3:0][10:0] lens;
        logic [3:0][11:0] dists;
        logic [3:0]       never;
        logic [1:0]       expIdx;
        logic [11:0]      expDist;
        logic             expTo;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    int curV = 0;
    logic [ADDR_W-1:0] curLens [4];
    logic [DATA_W-1:0] curDists [4];
    logic [3:0]        curNever = 4'b0000;

    logic [DATA_W-1:0] sampQ [$];
    logic [DATA_W-1:0] testQ [$];
    logic monEn = 1'b0;
    logic prevS = 1'b0;
    logic prevT = 1'b0;
    int sampCnt = 0, testCnt = 0, startCnt = 0, rstCnt = 0, doneCnt = 0;
    logic busyAtDone = 1'b0;

    assign tmpl_len = curLens[tmpl_idx];

    function automatic logic [DATA_W-1:0] tmplWord(int v, int t, int a);
        return DATA_W'(100 * t + 3 * a + 17 + 5 * v);
    endfunction

    function automatic logic [DATA_W-1:0] testWord(int v, int i);
        return DATA_W'((i + 1) * 10 + 3 * v);
    endfunction

    function automatic vec_t mkVec(int tl, int l0, int l1, int l2, int l3,
                                   int d0, int d1, int d2, int d3,
                                   logic [3:0] nv, int ei, int ed, logic et);
        vec_t r;
        r.testLen  = 11'(tl);
        r.lens[0]  = 11'(l0);
        r.lens[1]  = 11'(l1);
        r.lens[2]  = 11'(l2);
        r.lens[3]  = 11'(l3);
        r.dists[0] = 12'(d0);
        r.dists[1] = 12'(d1);
        r.dists[2] = 12'(d2);
        r.dists[3] = 12'(d3);
        r.never    = nv;
        r.expIdx   = 2'(ei);
        r.expDist  = 12'(ed);
        r.expTo    = et;
        return r;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // External template memory: address sampled on the edge, data one cycle later.
    initial begin
        logic [ADDR_W-1:0] a;
        logic [TI_W-1:0]   t;
        tmpl_data = '0;
        forever begin
            @(negedge clk);
            a = tmpl_addr;
            t = tmpl_idx;
            @(posedge clk);
            #1 tmpl_data = tmplWord(curV, int'(t), int'(a));
        end
    end

    // DTW core stand-in: answers a Start after a few cycles unless told to stay silent.
    initial begin
        logic [TI_W-1:0] t;
        valid = 1'b0;
        Out_Euclidean_Distatnce = '0;
        forever begin
            @(negedge clk);
            if (Start) begin
                t = tmpl_idx;
                repeat (3) @(negedge clk);
                if (!curNever[t]) begin
                    valid = 1'b1;
                    Out_Euclidean_Distatnce = curDists[t];
                    @(negedge clk);
                    valid = 1'b0;
                end
            end
        end
    end

    // Stream monitor and event counters.
    initial begin
        logic [DATA_W-1:0] e;
        logic riseS, riseT;
        forever begin
            @(negedge clk);
            riseS = StartReceiveSample && !prevS;
            riseT = StartReceiveTest && !prevT;
            if (StartReceiveSample) begin
                sampCnt++;
                if (monEn) begin
                    checkOutput("sample_queue_nonempty", 32'(sampQ.size() != 0), 32'd1);
                    if (sampQ.size() != 0) begin
                        e = sampQ.pop_front();
                        checkOutput("InSample", 32'(InSample), 32'(e));
                    end
                end
            end
            if (StartReceiveTest) begin
                testCnt++;
                if (monEn) begin
                    checkOutput("test_queue_nonempty", 32'(testQ.size() != 0), 32'd1);
                    if (testQ.size() != 0) begin
                        e = testQ.pop_front();
                        checkOutput("InTest", 32'(InTest), 32'(e));
                    end
                end
            end
            if (monEn && (riseS || riseT)) begin
                checkOutput("strobe_align", 32'(riseS), 32'(riseT));
            end
            if (Start) startCnt++;
            if (dtw_rst) rstCnt++;
            if (done) begin
                doneCnt++;
                busyAtDone = busy;
            end
            prevS = StartReceiveSample;
            prevT = StartReceiveTest;
        end
    end

    task automatic loadTest(int v);
        @(negedge clk);
        test_clear = 1'b1;
        @(negedge clk);
        test_clear = 1'b0;
        for (int i = 0; i < int'(vecs[v].testLen); i++) begin
            test_wr_en   = 1'b1;
            test_wr_data = testWord(v, i);
            @(negedge clk);
        end
        test_wr_en = 1'b0;
        curV = v;
        for (int t = 0; t < 4; t++) begin
            curLens[t]  = vecs[v].lens[t];
            curDists[t] = vecs[v].dists[t];
        end
        curNever = vecs[v].never;
    endtask

    task automatic applyStimulus(int v);
        int n;
        int nz;
        int sumLen;
        loadTest(v);
        checkOutput("test_len_loaded", 32'(test_len), 32'(vecs[v].testLen));
        nz = 0;
        sumLen = 0;
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < int'(vecs[v].lens[t]); a++) sampQ.push_back(tmplWord(v, t, a));
            if (vecs[v].lens[t] != 0) begin
                nz++;
                for (int i = 0; i < int'(vecs[v].testLen); i++) testQ.push_back(testWord(v, i));
            end
            sumLen += int'(vecs[v].lens[t]);
        end
        sampCnt = 0; testCnt = 0; startCnt = 0; rstCnt = 0; doneCnt = 0;
        monEn = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checkOutput("busy_after_go", 32'(busy), 32'd1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (doneCnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        monEn = 1'b0;
        checkOutput("done_pulses", 32'(doneCnt), 32'd1);
        checkOutput("busy_at_done", 32'(busyAtDone), 32'd0);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("best_idx", 32'(best_idx), 32'(vecs[v].expIdx));
        checkOutput("best_dist", 32'(best_dist), 32'(vecs[v].expDist));
        checkOutput("timeout", 32'(timeout), 32'(vecs[v].expTo));
        checkOutput("start_pulses", 32'(startCnt), 32'(nz));
        checkOutput("dtw_rst_pulses", 32'(rstCnt), 32'd4);
        checkOutput("sample_strobe_cycles", 32'(sampCnt), 32'(sumLen));
        checkOutput("test_strobe_cycles", 32'(testCnt), 32'(nz * int'(vecs[v].testLen)));
        checkOutput("sample_queue_left", 32'(sampQ.size()), 32'd0);
        checkOutput("test_queue_left", 32'(testQ.size()), 32'd0);
        sampQ.delete();
        testQ.delete();
    endtask

    initial begin
        int n;
        int busySeen;
        vecs[0] = mkVec(5, 5, 5, 5, 5, 300, 120, 120, 500, 4'b0000, 1, 120, 1'b0);
        vecs[1] = mkVec(8, 3, 3, 3, 3, 700, 650, 800, 651, 4'b0000, 1, 650, 1'b0);
        vecs[2] = mkVec(4, 2, 6, 4, 1, 900, 900, 0, 1000, 4'b0100, 0, 900, 1'b1);
        vecs[3] = mkVec(3, 0, 5, 2, 7, 5, 2000, 100, 100, 4'b0000, 2, 100, 1'b0);
        vecs[4] = mkVec(2, 1, 1, 1, 1, 7, 7, 7, 7, 4'b1111, 0, 4095, 1'b1);
        vecs[5] = mkVec(1, 1, 2, 3, 4, 4095, 4094, 10, 9, 4'b0000, 3, 9, 1'b0);
        for (int t = 0; t < 4; t++) begin
            curLens[t]  = '0;
            curDists[t] = '0;
        end

        rst = 1'b1;
        go = 1'b0;
        test_wr_en = 1'b0;
        test_wr_data = '0;
        test_clear = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_best_dist", 32'(best_dist), 32'hFFF);
        checkOutput("reset_best_idx", 32'(best_idx), 32'd0);
        checkOutput("reset_test_len", 32'(test_len), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_strobes", 32'({StartReceiveSample, StartReceiveTest, Start, dtw_rst, done}), 32'd0);
        checkOutput("reset_data", 32'({InSample, InTest}), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            $display("[TB] scan vector %0d", v);
            applyStimulus(v);
        end

        // Fill the test buffer to capacity, then push one sample too many.
        @(negedge clk);
        test_clear = 1'b1;
        @(negedge clk);
        test_clear = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            test_wr_en   = 1'b1;
            test_wr_data = DATA_W'(i);
            @(negedge clk);
            if (i == 2045) checkOutput("not_full_at_2046", 32'(test_full), 32'd0);
            if (i == 2046) begin
                checkOutput("full_len", 32'(test_len), 32'd2047);
                checkOutput("full_flag", 32'(test_full), 32'd1);
            end
        end
        test_wr_en = 1'b0;
        checkOutput("overflow_dropped", 32'(test_len), 32'd2047);

        // Clear beats a simultaneous write; go on an empty buffer does nothing.
        test_clear = 1'b1;
        test_wr_en = 1'b1;
        @(negedge clk);
        test_clear = 1'b0;
        test_wr_en = 1'b0;
        checkOutput("clear_wins", 32'(test_len), 32'd0);
        doneCnt = 0;
        busySeen = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busySeen++;
            @(negedge clk);
        end
        checkOutput("empty_go_busy", 32'(busySeen), 32'd0);
        checkOutput("empty_go_done", 32'(doneCnt), 32'd0);

        // Reset in the middle of streaming aborts the scan.
        loadTest(1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!StartReceiveTest && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("streaming_before_reset", 32'(StartReceiveTest), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_strobes", 32'({StartReceiveSample, StartReceiveTest}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_best_dist", 32'(best_dist), 32'hFFF);
        checkOutput("abort_test_len", 32'(test_len), 32'd0);
        rst = 1'b0;
        doneCnt = 0;
        repeat (40) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
